// File: rtl/mem_arbiter.sv
// Round-robin arbiter that funnels N_CH request channels into one memory port,
// keeping a single transaction outstanding and returning one-cycle responses.
module mem_arbiter #(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_CH-1:0]              req_valid,
    input  logic [N_CH*(DATA_W/8)-1:0]   req_we,
    input  logic [N_CH*ADDR_W-1:0]       req_addr,
    input  logic [N_CH*DATA_W-1:0]       req_wdata,
    output logic [N_CH-1:0]              req_ready,
    output logic [N_CH-1:0]              rsp_valid,
    output logic                         rsp_err,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_din,
    output logic [(DATA_W/8)-1:0]        mem_we,
    output logic                         mem_load,
    input  logic [DATA_W-1:0]            mem_dout,
    input  logic                         mem_done,
    output logic                         busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int GW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              r_state;
    logic [GW-1:0]       r_last;
    logic [GW-1:0]       r_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_we;
    logic [CNT_W-1:0]    r_cnt;
    logic [N_CH-1:0]     r_rspValid;
    logic                r_rspErr;
    logic [DATA_W-1:0]   r_rspRdata;

    logic                w_found;
    logic [GW-1:0]       w_grant;
    logic [N_CH-1:0]     w_oneHot;
    logic [ADDR_W-1:0]   w_selAddr;
    logic [DATA_W-1:0]   w_selWdata;
    logic [BE_W-1:0]     w_selWe;
    int                  w_dist;
    int                  w_best;

    // Each channel's distance from the slot after the last grant; the nearest valid one wins.
    always_comb begin
        w_found    = 1'b0;
        w_grant    = '0;
        w_oneHot   = '0;
        w_selAddr  = '0;
        w_selWdata = '0;
        w_selWe    = '0;
        w_best     = N_CH;
        w_dist     = 0;
        for (int i = 0; i < N_CH; i++) begin
            w_dist = (i + N_CH - 1 - int'(r_last)) % N_CH;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_found     = 1'b1;
                w_grant     = GW'(i);
                w_oneHot    = '0;
                w_oneHot[i] = 1'b1;
                w_selAddr   = req_addr[i*ADDR_W +: ADDR_W];
                w_selWdata  = req_wdata[i*DATA_W +: DATA_W];
                w_selWe     = req_we[i*BE_W +: BE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last     <= GW'(N_CH - 1);
            r_grant    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= '0;
            r_cnt      <= '0;
            r_rspValid <= '0;
            r_rspErr   <= 1'b0;
            r_rspRdata <= '0;
        end else begin
            r_rspValid <= '0;
            r_rspErr   <= 1'b0;
            r_rspRdata <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_grant;
                        r_last  <= w_grant;
                        r_addr  <= w_selAddr;
                        r_wdata <= w_selWdata;
                        r_we    <= w_selWe;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A completion in the last allowed cycle beats the timeout.
                    if (mem_done) begin
                        r_rspValid <= N_CH'(1) << r_grant;
                        r_rspRdata <= (r_we == '0) ? mem_dout : '0;
                        r_state    <= IDLE;
                    end else if ((TIMEOUT > 0) && (r_cnt == CNT_LAST)) begin
                        r_rspValid <= N_CH'(1) << r_grant;
                        r_rspErr   <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = ((r_state == IDLE) && !rst) ? w_oneHot : '0;
    assign rsp_valid = r_rspValid;
    assign rsp_err   = r_rspErr;
    assign rsp_rdata = r_rspRdata;
    assign mem_addr  = r_addr;
    assign mem_din   = r_wdata;
    assign mem_we    = (r_state == ISSUE) ? r_we : '0;
    assign mem_load  = (r_state == ISSUE) && (r_we == '0);
    assign busy      = (r_state != IDLE);

endmodule
